uc_mult_fsm: RTL and testbench
==============================

Name: uc_mult_fsm

Overview:
Explicit-FSM control unit for the N-bit shift-and-add multiplier datapath (registers M, A, Q; Q0 fed back).
- Sequences load, conditional add and shift for exactly N iterations.
- Adds a start/busy/done handshake and a parameterised iteration counter.
- Sits between the top-level sequencer (start/Fin) and the datapath register enables.

Parameters:
N, 4, operand width in bits = number of add/shift iterations (N >= 2)
CW, $clog2(N+1), iteration counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request new multiplication; sampled only in IDLE
q0  input  1  LSB of Q register from datapath
CargaM  output  1  load multiplicand register M
CargaQ  output  1  load multiplier register Q
ResetA  output  1  clear accumulator A
CargaA  output  1  A <= A + M (carry into A's extension bit)
DesplazaQ  output  1  shift {carry,A,Q} right one bit
Ocupado  output  1  operation in progress
Fin  output  1  one-cycle done pulse

Behaviour:
- Reset:
  - reset_n low -> state IDLE, counter 0, every output 0, immediately (asynchronous).
  - Deasserting reset leaves the block in IDLE.
- Outputs are Moore, decoded from the state register only. No output depends combinationally on start or q0.
- States and outputs:
  - IDLE: all outputs 0.
  - INIT: CargaM = CargaQ = ResetA = 1.
  - TEST: no enable asserted.
  - ADD: CargaA = 1.
  - SHIFT: DesplazaQ = 1.
  - DONE: Fin = 1.
- Ocupado = 1 in INIT, TEST, ADD, SHIFT; 0 in IDLE and DONE.
- Transitions:
  - IDLE -> INIT if start, else stay in IDLE.
  - INIT -> TEST; counter <= 0.
  - TEST -> ADD if q0, else TEST -> SHIFT.
  - ADD -> SHIFT.
  - SHIFT -> counter <= counter + 1. Go to DONE if counter == N-1, else back to TEST.
  - DONE -> IDLE unconditionally.
- Latency:
  - Start sampled at edge e0. INIT occupies cycle 1; DONE occupies cycle 2 + 2N + k, where k = number of 1 bits seen at q0 across the iterations.
  - Fin is high only in the DONE cycle.
- Handshake:
  - start is ignored outside IDLE, including during DONE.
  - start held high continuously gives back-to-back operations, separated by exactly one IDLE cycle.
- Counter:
  - Never exceeds N-1 before DONE and never wraps.
  - Held at its value in all states except INIT and SHIFT.
- Reset mid-operation: abandons the operation with no Fin pulse; datapath contents are then don't-care.
- Illegal/unused state encodings return to IDLE on the next edge.

Optional Feature:
Macro: UC_MULT_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - In INIT, TEST, ADD or SHIFT, abort = 1 forces next state IDLE and counter 0, with no Fin pulse.
  - abort has priority over every other transition. It is ignored in IDLE and DONE.
- Undefined: no abort port; behaviour exactly as above.

Decomposition:
- Shared include uc_mult_defs.vh holds:
  - state encoding localparams (IDLE, INIT, TEST, ADD, SHIFT, DONE; 3-bit binary);
  - CW derivation.
- One sub-module: contador_iter, a CW-bit counter with clear, enable and a terminal-count flag (count == N-1).
  - It uses the same clk/reset_n as uc_mult_fsm.
  - uc_mult_fsm instantiates it and contains the FSM plus the output decode.

Test Plan:
- Zero multiplier: N=4, q0 driven from a model Q=0000, start pulse 1 cycle.
  - Fin in cycle 10 after start edge.
  - CargaA never asserted; DesplazaQ asserted exactly 4 times.
  - Model result 0.
- Mixed multiplier: N=4, M=0101, Q=1011.
  - Fin at cycle 13; CargaA asserted 3 times.
  - Model product 00110111 (55).
- All ones: N=4, M=1111, Q=1111.
  - Fin at cycle 14; CargaA 4 times; product 11100001 (225), with the carry bit exercised.
- Start held high for 40 cycles with Q=0000.
  - Operations repeat with exactly one IDLE cycle between DONE and the next INIT.
  - Fin pulses are each 1 cycle wide.
  - start toggling while Ocupado=1 has no effect.
- Async reset mid-operation: reset_n low for half a cycle during the 2nd SHIFT.
  - All outputs go to 0 immediately; no Fin pulse.
  - The next start gives a full-length operation (counter restarted).
- With UC_MULT_ABORT_EN defined: assert abort in an ADD cycle.
  - Next cycle IDLE, Ocupado = 0, no Fin.
  - abort asserted in DONE: Fin still pulses normally.
  - Rerun with the macro undefined: the port is absent and the directed tests above still pass.

Source files
------------

// File: rtl/uc_mult_fsm_pkg.sv
// Shared definitions for the shift-and-add multiplier control unit: 3-bit binary
// state encoding and the iteration-counter width derivation.
package uc_mult_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_TEST  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // The counter must be able to hold N, the value it reaches on the final SHIFT.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uc_mult_fsm_contador_iter.sv
// Iteration counter for uc_mult_fsm: synchronous clear (priority over enable),
// increment enable and a terminal-count flag raised when the count equals N-1.
module contador_iter
  import uc_mult_fsm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_cnt <= '0;
    else if (clr)  r_cnt <= '0;
    else if (en)   r_cnt <= r_cnt + 1'b1;
  end

  assign tc = (r_cnt == LAST);

endmodule

// File: rtl/uc_mult_fsm.sv
// Moore control FSM for the N-bit shift-and-add multiplier datapath (M, A, Q).
// Optional abort input enabled by defining UC_MULT_ABORT_EN.
module uc_mult_fsm
  import uc_mult_fsm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic q0,
`ifdef UC_MULT_ABORT_EN
  input  logic abort,
`endif
  output logic CargaM,
  output logic CargaQ,
  output logic ResetA,
  output logic CargaA,
  output logic DesplazaQ,
  output logic Ocupado,
  output logic Fin
);

  state_e r_state;
  state_e w_next;
  logic   w_clr;
  logic   w_inc;
  logic   w_tc;
  logic   w_abort;

`ifdef UC_MULT_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  contador_iter #(.N(N)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .en      (w_inc),
    .tc      (w_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    w_clr  = 1'b0;
    w_inc  = 1'b0;
    case (r_state)
      ST_IDLE:  w_next = start ? ST_INIT : ST_IDLE;
      ST_INIT: begin
        w_next = ST_TEST;
        w_clr  = 1'b1;
      end
      ST_TEST:  w_next = q0 ? ST_ADD : ST_SHIFT;
      ST_ADD:   w_next = ST_SHIFT;
      ST_SHIFT: begin
        w_inc  = 1'b1;
        w_next = w_tc ? ST_DONE : ST_TEST;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    // Abort wins over every transition while busy and restarts the count.
    if (w_abort && (r_state inside {ST_INIT, ST_TEST, ST_ADD, ST_SHIFT})) begin
      w_next = ST_IDLE;
      w_clr  = 1'b1;
      w_inc  = 1'b0;
    end
  end

  always_comb begin
    CargaM    = 1'b0;
    CargaQ    = 1'b0;
    ResetA    = 1'b0;
    CargaA    = 1'b0;
    DesplazaQ = 1'b0;
    Ocupado   = 1'b0;
    Fin       = 1'b0;
    case (r_state)
      ST_INIT: begin
        CargaM  = 1'b1;
        CargaQ  = 1'b1;
        ResetA  = 1'b1;
        Ocupado = 1'b1;
      end
      ST_TEST:  Ocupado = 1'b1;
      ST_ADD: begin
        CargaA  = 1'b1;
        Ocupado = 1'b1;
      end
      ST_SHIFT: begin
        DesplazaQ = 1'b1;
        Ocupado   = 1'b1;
      end
      ST_DONE:  Fin = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_mult_fsm.sv
// Directed + randomized bench for uc_mult_fsm with a small datapath model feeding q0
// and expectations derived from the multiplication itself.
module tb_uc_mult_fsm;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic q0;
  logic CargaM, CargaQ, ResetA, CargaA, DesplazaQ, Ocupado, Fin;
  logic [6:0] outs;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] m_in = '0;
  logic [N-1:0] q_in = '0;
  logic [N-1:0] dp_m = '0;
  logic [N-1:0] dp_a = '0;
  logic [N-1:0] dp_q = '0;
  logic         dp_c = 1'b0;

  always #5 clk = ~clk;

  uc_mult_fsm #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .q0        (q0),
`ifdef UC_MULT_ABORT_EN
    .abort     (abort),
`endif
    .CargaM    (CargaM),
    .CargaQ    (CargaQ),
    .ResetA    (ResetA),
    .CargaA    (CargaA),
    .DesplazaQ (DesplazaQ),
    .Ocupado   (Ocupado),
    .Fin       (Fin)
  );

  assign outs = {CargaM, CargaQ, ResetA, CargaA, DesplazaQ, Ocupado, Fin};
  assign q0   = dp_q[0];

  // Datapath registers driven by the DUT enables.
  always @(posedge clk) begin
    if (CargaM) dp_m <= m_in;
    if (CargaQ) dp_q <= q_in;
    if (ResetA) begin
      dp_a <= '0;
      dp_c <= 1'b0;
    end
    if (CargaA) {dp_c, dp_a} <= {1'b0, dp_a} + {1'b0, dp_m};
    if (DesplazaQ) begin
      dp_c <= 1'b0;
      dp_a <= {dp_c, dp_a[N-1:1]};
      dp_q <= {dp_a[0], dp_q[N-1:1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q, input bit abort_done);
    int ef, got, na, nd, busy_bad;
    logic [2*N-1:0] prod;
    ef = 2 + 2*N + $countones(q);
    got = 0; na = 0; nd = 0; busy_bad = 0;
    m_in = m;
    q_in = q;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60 && got == 0; c++) begin
      @(negedge clk);
      if (c == 1) chk("init_outs", 32'(outs), 32'b1110010);
      if (CargaA) na++;
      if (DesplazaQ) nd++;
      if (Fin) begin
        got = c;
        chk("done_outs", 32'(outs), 32'b0000001);
      end else if (!Ocupado) begin
        busy_bad++;
      end
      start = 1'($urandom_range(0, 1));
      abort = Fin && abort_done;
    end
    @(negedge clk);
    chk("idle_after_done", 32'(outs), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    prod = {dp_a, dp_q};
    chk("fin_cycle", 32'(got), 32'(ef));
    chk("carga_a_count", 32'(na), 32'($countones(q)));
    chk("desplaza_count", 32'(nd), 32'(N));
    chk("busy_gaps", 32'(busy_bad), 32'd0);
    chk("product", 32'(prod), 32'(m * q));
  endtask

  initial begin
    int bad, fins;
    #2 reset_n = 1'b0;
    #1 chk("reset_outs", 32'(outs), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 32'(outs), 32'd0);

    run_op(4'b1001, 4'b0000, 1'b0);
    run_op(4'b0101, 4'b1011, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b0);
    repeat (6) run_op(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)), 1'b0);

    // Start held high: one IDLE cycle between DONE and the next INIT.
    m_in = 4'd6;
    q_in = 4'd0;
    bad = 0;
    fins = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      bit fin_e, busy_e;
      @(negedge clk);
      fin_e  = (c >= 10) && ((c - 10) % 11 == 0);
      busy_e = !fin_e && !((c >= 11) && ((c - 11) % 11 == 0));
      if (Fin) fins++;
      if (Fin !== fin_e || Ocupado !== busy_e) bad++;
    end
    chk("b2b_pattern", 32'(bad), 32'd0);
    chk("b2b_fin_pulses", 32'(fins), 32'd3);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_idle", 32'(outs), 32'd0);

    // Asynchronous reset during the second SHIFT.
    m_in = 4'd3;
    q_in = 4'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("shift2_before_reset", 32'(DesplazaQ), 32'd1);
    reset_n = 1'b0;
    #1 chk("async_reset_outs", 32'(outs), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (Fin || Ocupado) bad++;
    end
    chk("no_fin_after_reset", 32'(bad), 32'd0);
    run_op(4'b0101, 4'b1011, 1'b0);

`ifdef UC_MULT_ABORT_EN
    m_in = 4'd7;
    q_in = 4'b1111;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("add_before_abort", 32'(CargaA), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(outs), 32'd0);
    abort = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (Fin || Ocupado) bad++;
    end
    chk("no_fin_after_abort", 32'(bad), 32'd0);
    run_op(4'b1001, 4'b0110, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
